// File: rtl/multdiv_pkg.sv
// Shared multdiv definitions: operand width, counter width,
// FSM state encoding.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } md_state_e;

endpackage

// File: rtl/booth_mult_64_if.sv
// Multiplier request/result bundle.
// master: start, multiplicand, multiplier -> product, result_rdy, overflow, busy.
interface booth_mult_64_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 result_rdy;
  logic                 overflow;
  logic                 busy;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  product,
    input  result_rdy,
    input  overflow,
    input  busy
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output product,
    output result_rdy,
    output overflow,
    output busy
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: WIDTH+1 add/sub then arithmetic shift.
// In: hi_i, lo_i, qm1_i, a_i. Out: next hi_o, lo_o, qm1_o.
module booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             qm1_o
);

  logic [WIDTH:0] hx;
  logic [WIDTH:0] ax;
  logic [WIDTH:0] sum;
  logic           add;
  logic           sub;

  assign hx  = {hi_i[WIDTH-1], hi_i};
  assign ax  = {a_i[WIDTH-1], a_i};
  assign add = ~lo_i[0] & qm1_i;
  assign sub = lo_i[0] & ~qm1_i;

  always_comb begin
    sum = hx;
    unique case (1'b1)
      add:     sum = hx + ax;
      sub:     sum = hx - ax;
      default: sum = hx;
    endcase
  end

  // Sign comes from the extra sum bit so -(-2^(W-1)) stays exact.
  assign hi_o  = sum[WIDTH:1];
  assign lo_o  = {sum[0], lo_i[WIDTH-1:1]};
  assign qm1_o = lo_i[0];

endmodule

// File: rtl/booth_mult_64.sv
// Iterative radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH signed.
// Ports: clk, clr_n (async low), bus (slave: start/operands in, product/rdy/ovf/busy out).
module booth_mult_64
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic             clk,
  input logic             clr_n,
  booth_mult_64_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               step_qm1;
  logic [WIDTH:0]     top_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .qm1_i (qm1_q),
    .a_i   (a_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo),
    .qm1_o (step_qm1)
  );

  // Bits that must all match for the product to fit in WIDTH signed.
  assign top_n = {step_hi, step_lo[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    rdy_d   = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        qm1_d   = step_qm1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
          ovf_d   = ~((&top_n) | ~(|top_n));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new request wins in every state, aborting any running op.
    if (bus.start) begin
      state_d = S_BUSY;
      count_d = '0;
      a_d     = bus.multiplicand;
      hi_d    = '0;
      lo_d    = bus.multiplier;
      qm1_d   = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.product    = {hi_q, lo_q};
  assign bus.result_rdy = rdy_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state_q == S_BUSY);

endmodule

// File: tb/tb_booth_mult_64.sv
// Bench for booth_mult_64: directed corners plus
// randomized back-to-back ops against a signed reference.
module tb_booth_mult_64;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;

  booth_mult_64_if bus ();

  booth_mult_64 dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint ref_prod(logic [31:0] a, logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic ref_ovf(longint p);
    longint lim;
    lim = longint'(32'sh7FFF_FFFF);
    return (p > lim) || (p < -lim - 1);
  endfunction

  // Called #1 after a start edge with start already low.
  task automatic wait_result(output int rdy_edge, output int busy_n,
                             output logic [63:0] prod, output logic ovf);
    rdy_edge = -1;
    busy_n   = bus.busy ? 1 : 0;
    prod     = '0;
    ovf      = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.result_rdy) begin
        rdy_edge = e;
        prod     = bus.product;
        ovf      = bus.overflow;
        break;
      end
    end
  endtask

  task automatic issue_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #3;
    n_checks++;
    if ({bus.busy, bus.result_rdy, bus.overflow} !== 3'b000 ||
        bus.product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rdy=%b ovf=%b prod=%h required 0",
               bus.busy, bus.result_rdy, bus.overflow, bus.product);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_directed(input string nm, input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [63:0] exp_p,
                               input logic exp_o);
    int re, bn;
    logic [63:0] p;
    logic o;
    issue_start(a, b);
    wait_result(re, bn, p, o);
    n_checks++;
    if (re !== 32) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required 32", nm, re);
    end
    n_checks++;
    if (p !== exp_p) begin
      n_fail++;
      $display("FAIL %s product: got %h required %h", nm, p, exp_p);
    end
    n_checks++;
    if (o !== exp_o) begin
      n_fail++;
      $display("FAIL %s overflow: got %b required %b", nm, o, exp_o);
    end
    n_checks++;
    if (bn !== 32) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d required 32", nm, bn);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.result_rdy !== 1'b0 || bus.busy !== 1'b0 ||
        bus.product !== exp_p || bus.overflow !== exp_o) begin
      n_fail++;
      $display("FAIL %s hold: rdy=%b busy=%b prod=%h ovf=%b required 0 0 %h %b",
               nm, bus.result_rdy, bus.busy, bus.product, bus.overflow,
               exp_p, exp_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    int spurious;
    issue_start(32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.result_rdy} !== 2'b00 || bus.product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b rdy=%b prod=%h required 0",
               bus.busy, bus.result_rdy, bus.product);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.result_rdy || bus.busy) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: got %0d active cycles required 0",
               spurious);
    end
  endtask

  task automatic test_restart();
    int re, bn, spurious;
    logic [63:0] p;
    logic o;
    issue_start(32'd7, 32'd6);
    spurious = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (bus.result_rdy) spurious++;
    end
    bus.start        = 1'b1;
    bus.multiplicand = 32'hFFFF_FFFF;
    bus.multiplier   = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_result(re, bn, p, o);
    n_checks++;
    if (spurious !== 0 || re !== 32) begin
      n_fail++;
      $display("FAIL restart_timing: early=%0d latency=%0d required 0 and 32",
               spurious, re);
    end
    n_checks++;
    if (p !== 64'd1) begin
      n_fail++;
      $display("FAIL restart_product: got %h required 1", p);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int re, bn, bad, pulses;
    logic [63:0] p;
    logic o;
    longint ep;
    for (int i = 0; i < 200; i++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
    qa[10] = 32'h8000_0000; qb[10] = 32'h8000_0000;
    qa[20] = 32'h0;         qb[20] = 32'h8000_0000;
    bad = 0;
    pulses = 0;
    issue_start(qa[0], qb[0]);
    for (int i = 0; i < 200; i++) begin
      wait_result(re, bn, p, o);
      if (re == 32) pulses++;
      ep = ref_prod(qa[i], qb[i]);
      n_checks++;
      if (re !== 32 || p !== 64'(ep) || o !== ref_ovf(ep)) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL b2b op%0d: a=%h b=%h lat=%0d prod=%h ovf=%b required lat=32 prod=%h ovf=%b",
                   i, qa[i], qb[i], re, p, o, 64'(ep), ref_ovf(ep));
      end
      if (i < 199) begin
        bus.start        = 1'b1;
        bus.multiplicand = qa[i+1];
        bus.multiplier   = qb[i+1];
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    n_checks++;
    if (pulses !== 200) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d required 200", pulses);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed("basic", 32'd3, 32'hFFFF_FFFB,
                  64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    test_directed("min_sq", 32'h8000_0000, 32'h8000_0000,
                  64'h4000_0000_0000_0000, 1'b1);
    test_directed("min_x1", 32'h8000_0000, 32'd1,
                  64'hFFFF_FFFF_8000_0000, 1'b0);
    test_directed("max_x2", 32'h7FFF_FFFF, 32'd2,
                  64'h0000_0000_FFFF_FFFE, 1'b1);
    test_directed("q_xm2", 32'h4000_0000, 32'hFFFF_FFFE,
                  64'hFFFF_FFFF_8000_0000, 1'b0);
    test_reset_mid_busy();
    test_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
